adder_rr_arbiter: RTL
=====================

ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set operand and result width.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-003 Parameter TAG_DEPTH, default 4, SHALL set the maximum number of in-flight operations.
REQ-004 clk  in  1  clock; all logic SHALL be rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_vld  in  NUM_REQ  per-requester operation valid.
REQ-007 req_rdy  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-008 req_ops  in  NUM_REQ*6*DATA_WIDTH  six operands a..f per requester; requester i, operand k at slice (i*6+k).
REQ-009 pe_vld  out  1  operation valid towards the 6-input adder pipeline.
REQ-010 pe_rdy  in  1  adder pipeline ready.
REQ-011 pe_ops  out  6*DATA_WIDTH  operands a..f towards the pipeline.
REQ-012 pe_res_vld  in  1  result valid from the pipeline.
REQ-013 pe_res_rdy  out  1  result accept towards the pipeline.
REQ-014 pe_res  in  DATA_WIDTH  pipeline result.
REQ-015 rsp_vld  out  NUM_REQ  per-requester result valid, one-hot or zero.
REQ-016 rsp_rdy  in  NUM_REQ  per-requester result ready.
REQ-017 rsp_data  out  DATA_WIDTH  result, shared by all requesters.
REQ-018 inflight  out  clog2(TAG_DEPTH+1)  in-flight operation count.
REQ-019 err_orphan  out  1  sticky flag: result arrived with no outstanding tag.

Function
REQ-020 Issue slot SHALL be a registered slice: slot_free = ~pe_vld | pe_rdy.
REQ-021 A grant SHALL occur when slot_free, inflight < TAG_DEPTH, and any req_vld; a pop in the same cycle SHALL NOT unblock a full count.
REQ-022 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant updates only on grant.
REQ-023 req_rdy SHALL be the combinational one-hot grant; handshake = req_vld[i] & req_rdy[i].
REQ-024 On grant in cycle N, pe_ops SHALL load the granted operands and pe_vld SHALL be 1 from cycle N+1.
REQ-025 pe_vld SHALL clear when pe_rdy=1 and no new grant; pe_ops SHALL hold while pe_vld & ~pe_rdy.
REQ-026 On grant, the granted index SHALL be pushed to a tag FIFO (depth TAG_DEPTH, in-order).
REQ-027 rsp_vld[i] SHALL equal pe_res_vld & tag_nonempty & (tag_head == i); rsp_data SHALL equal pe_res combinationally.
REQ-028 pe_res_rdy SHALL equal tag_nonempty & rsp_rdy[tag_head]; a result handshake SHALL pop the tag FIFO.
REQ-029 inflight SHALL increment on grant, decrement on pop, and remain unchanged on both in the same cycle.
REQ-030 If pe_res_vld=1 while the tag FIFO is empty: pe_res_rdy=0, all rsp_vld=0, err_orphan set until rst.
REQ-031 A stalled requester (rsp_rdy=0) SHALL back-pressure the pipeline without affecting grants until inflight reaches TAG_DEPTH.

Reset
REQ-032 On rst: pe_vld=0, tag FIFO empty, inflight=0, err_orphan=0, last_grant=NUM_REQ-1 (requester 0 first); pe_ops are not reset.
REQ-033 rst asserted mid-operation SHALL discard all tags in the next cycle; results arriving afterwards set err_orphan.

Structure
REQ-034 Package adder_arb_pkg SHALL hold NUM_OPS=6, default DATA_WIDTH/NUM_REQ/TAG_DEPTH, and the tag_t typedef (clog2(NUM_REQ) bits).
REQ-035 The tag FIFO SHALL be a sub-module tag_fifo (synchronous, full/empty/count outputs); the adder pipeline SHALL NOT be instantiated inside.

Verification
REQ-036 All 4 req_vld held high, pe_rdy=1, rsp_rdy=all 1 -> grants 0,1,2,3,0 on consecutive cycles; results return in the same order.
REQ-037 Requester 2 only, operands 1..6 -> pe_vld one cycle after req handshake, pe_ops={1..6}; result 21 delivered as rsp_vld=4'b0100, rsp_data=21.
REQ-038 pe_rdy=0 for 5 cycles with req 1 pending -> pe_vld and pe_ops stable, req_rdy=0 throughout, single issue on release.
REQ-039 rsp_rdy=0, 5 back-to-back requests -> exactly 4 grants, inflight=4, 5th grant only after one result pop.
REQ-040 pe_res_vld=1 after reset with no issue -> pe_res_rdy=0, rsp_vld=0, err_orphan=1 and held.
REQ-041 rst mid-stream with 3 in flight -> inflight=0, pe_vld=0 next cycle; next grant goes to requester 0.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg
// Shared constants and types for the round-robin front end of the
// six-input adder pipeline.
//   NUM_OPS          operands per operation (a..f)
//   DEF_DATA_WIDTH   default operand/result width
//   DEF_NUM_REQ      default number of requesters
//   DEF_TAG_DEPTH    default number of operations allowed in flight
//   tag_t            requester index carried through the tag FIFO
package adder_arb_pkg;

  localparam int NUM_OPS        = 6;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_TAG_DEPTH  = 4;
  localparam int TAG_BITS       = $clog2(DEF_NUM_REQ);

  typedef logic [TAG_BITS-1:0] tag_t;

endpackage

// File: rtl/tag_fifo.sv
// tag_fifo
// In-order FIFO of requester indices, one entry per operation currently in
// the adder pipeline. The head tells the response side which requester owns
// the result that arrives next.
//   clk, rst      rising-edge clock, synchronous active-high reset (empties FIFO)
//   push_i        write push_data_i (ignored when full)
//   push_data_i   requester index of the operation just issued
//   pop_i         drop the head entry (ignored when empty)
//   head_o        oldest stored index
//   full_o        count equals DEPTH
//   empty_o       count equals zero
//   count_o       number of stored entries
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = do_push ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? bump(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter
// Round-robin front end that shares one external six-input adder pipeline
// among NUM_REQ requesters and routes each result back to its owner.
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req_vld / req_rdy         per-requester operation handshake (rdy one-hot)
//   req_ops                   six operands per requester, requester i operand k
//                             at slice (i*6+k)
//   pe_vld / pe_rdy / pe_ops  registered issue slot towards the pipeline
//   pe_res_vld / pe_res_rdy   result handshake from the pipeline
//   pe_res                    pipeline result
//   rsp_vld / rsp_rdy         per-requester result handshake (vld one-hot)
//   rsp_data                  result, shared by all requesters
//   inflight                  operations issued but not yet answered
//   err_orphan                sticky: a result arrived with no outstanding tag
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int TAG_DEPTH  = DEF_TAG_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_vld,
  output logic [NUM_REQ-1:0]                    req_rdy,
  input  logic [NUM_REQ*NUM_OPS*DATA_WIDTH-1:0] req_ops,
  output logic                                  pe_vld,
  input  logic                                  pe_rdy,
  output logic [NUM_OPS*DATA_WIDTH-1:0]         pe_ops,
  input  logic                                  pe_res_vld,
  output logic                                  pe_res_rdy,
  input  logic [DATA_WIDTH-1:0]                 pe_res,
  output logic [NUM_REQ-1:0]                    rsp_vld,
  input  logic [NUM_REQ-1:0]                    rsp_rdy,
  output logic [DATA_WIDTH-1:0]                 rsp_data,
  output logic [$clog2(TAG_DEPTH+1)-1:0]        inflight,
  output logic                                  err_orphan
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OPS_W = NUM_OPS * DATA_WIDTH;

  logic                 pe_vld_q, pe_vld_d;
  logic [OPS_W-1:0]     pe_ops_q;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic                 err_orphan_q, err_orphan_d;

  logic [NUM_REQ-1:0]   grant_oh;
  logic [IDX_W-1:0]     grant_idx;
  logic [OPS_W-1:0]     grant_ops;
  logic                 grant_fire;
  logic                 slot_free;
  logic                 tag_full, tag_empty;
  logic [IDX_W-1:0]     tag_head;
  logic                 res_pop;

  // The slot accepts a new operation when empty or when it drains this
  // cycle. tag_full is the registered count, so a result pop in the same
  // cycle deliberately does not open a grant on a full FIFO.
  assign slot_free  = ~pe_vld_q | pe_rdy;
  assign grant_fire = ~rst & slot_free & ~tag_full & (|req_vld);

  // Walk the requesters starting just after the last winner; the first
  // active one wins.
  always_comb begin
    logic [IDX_W-1:0] cur;
    grant_oh  = '0;
    grant_idx = '0;
    cur       = last_grant_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cur = (cur == IDX_W'(NUM_REQ - 1)) ? '0 : cur + 1'b1;
      if ((grant_oh == '0) && req_vld[cur]) begin
        grant_oh[cur] = 1'b1;
        grant_idx     = cur;
      end
    end
  end

  always_comb begin
    grant_ops = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        grant_ops = req_ops[i*OPS_W +: OPS_W];
      end
    end
  end

  assign req_rdy = grant_fire ? grant_oh : '0;

  // A new grant refills the slot; otherwise a taken operation empties it and
  // a stalled one simply holds.
  always_comb begin
    pe_vld_d     = pe_vld_q;
    last_grant_d = last_grant_q;
    err_orphan_d = err_orphan_q | (pe_res_vld & tag_empty);
    if (grant_fire) begin
      pe_vld_d     = 1'b1;
      last_grant_d = grant_idx;
    end else if (pe_rdy) begin
      pe_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_vld_q     <= 1'b0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      err_orphan_q <= 1'b0;
    end else begin
      pe_vld_q     <= pe_vld_d;
      last_grant_q <= last_grant_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Operand register is data only and is never reset.
  always_ff @(posedge clk) begin
    if (grant_fire) begin
      pe_ops_q <= grant_ops;
    end
  end

  // Results come back in issue order, so the FIFO head names the owner.
  // An empty FIFO hides the result entirely and leaves it unaccepted.
  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_vld[i] = pe_res_vld & ~tag_empty & (tag_head == IDX_W'(i));
    end
  end

  assign pe_res_rdy = ~tag_empty & rsp_rdy[tag_head];
  assign res_pop    = pe_res_vld & pe_res_rdy;
  assign rsp_data   = pe_res;
  assign pe_vld     = pe_vld_q;
  assign pe_ops     = pe_ops_q;
  assign err_orphan = err_orphan_q;

  tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (IDX_W)
  ) u_tags (
    .clk         (clk),
    .rst         (rst),
    .push_i      (grant_fire),
    .push_data_i (grant_idx),
    .pop_i       (res_pop),
    .head_o      (tag_head),
    .full_o      (tag_full),
    .empty_o     (tag_empty),
    .count_o     (inflight)
  );

endmodule
